pwm_capture_sequencer: RTL and testbench
========================================

# pwm_capture_sequencer

Time-multiplexed PWM measurement controller for the colorwheel datapath. It scans NUM_CH PWM lines (the R, G and B drive signals by default) in round-robin order and locks onto each channel's period. It accumulates high and low interval counts over 2^AVG_LOG2 full periods and publishes averaged results to the Microblaze GPIO with a valid/ack handshake. A per-channel timeout reports stuck-at-0 and stuck-at-1 lines (0% and 100% duty) instead of hanging.

## Interface
- NUM_CH, 3, number of PWM inputs scanned (2..16)
- CNT_W, 32, width of the published high/low averages
- AVG_LOG2, 2, log2 of the number of periods averaged per measurement
- TIMEOUT_CYCLES, 2000000, cycles without an edge on the selected channel before a timeout result is published
- clk  in  1  system clock, 100 MHz
- reset  in  1  synchronous, active-high
- pwm_in  in  NUM_CH  asynchronous PWM lines; bit i is channel i
- enable  in  1  scan enable; low aborts and parks in IDLE
- ack  in  1  consumer acknowledge; sampled only while result_valid=1
- result_valid  out  1  result registers hold an unacknowledged result
- result_ch  out  $clog2(NUM_CH)  channel the result belongs to
- high_avg  out  CNT_W  averaged high interval, in clk cycles
- low_avg  out  CNT_W  averaged low interval, in clk cycles
- timeout  out  1  result produced by the timeout path
- busy  out  1  high whenever state is not IDLE

## Operation
- Every channel passes through a 2-flop synchronizer (s1, s2) plus a history flop s3, all updated every cycle for all channels.
  - rise[i] = s2 & ~s3; fall[i] = ~s2 & s3.
  - Because history runs continuously, switching channels never creates a false edge.
- Per-channel registers: cur_ch, hcnt and lcnt (CNT_W, saturating), hacc and lacc (CNT_W+AVG_LOG2), nper (AVG_LOG2+1 bits), tcnt (timeout counter).
- IDLE: cur_ch=0. When enable=1, go to SYNC with tcnt=0.
- SYNC: wait for rise[cur_ch]. On the rise, go to MEASURE with hcnt=1, lcnt=0, hacc=lacc=0, nper=0.
- MEASURE: each cycle, hcnt increments if s2[cur_ch]=1, otherwise lcnt increments.
  - On rise[cur_ch] a period completes: hacc+=hcnt, lacc+=lcnt, nper+=1, then hcnt=1, lcnt=0.
  - When nper reaches 2^AVG_LOG2, go to PUBLISH.
- Timeout path: in SYNC or MEASURE, tcnt clears on any rise or fall of cur_ch and increments otherwise.
  - When tcnt reaches TIMEOUT_CYCLES-1, go to PUBLISH with timeout=1.
  - If s2[cur_ch]=1: high_avg=TIMEOUT_CYCLES, low_avg=0. If s2[cur_ch]=0: high_avg=0, low_avg=TIMEOUT_CYCLES.
- Normal publish: high_avg = hacc>>AVG_LOG2, low_avg = lacc>>AVG_LOG2 (truncating), timeout=0, result_ch=cur_ch.
- PUBLISH: result_valid=1 and all result outputs hold stable.
  - On ack=1: clear result_valid, cur_ch = (cur_ch==NUM_CH-1) ? 0 : cur_ch+1, go to SYNC with tcnt=0.
  - While ack=0 the scan stalls indefinitely; no other channel is measured.
- ack while result_valid=0 is ignored.
- enable=0 in any state: next state is IDLE, result_valid=0, cur_ch=0, any partial measurement is discarded.
- If a period completion and the timeout threshold coincide, the period completion wins (an edge clears tcnt).

## Timing
- Reset values:
  - result_valid=0, result_ch=0, high_avg=0, low_avg=0, timeout=0, busy=0.
  - state=IDLE, all synchronizer, history and counter flops =0.
- Reset mid-operation abandons everything; no result is published.
- Pin-to-decision latency is 3 clk edges (s1, s2, then the state update). The latency is identical for both edges, so measured intervals are exact for transitions held at least 2 cycles.
- Results load on the same edge that enters PUBLISH, and result_valid rises on that edge.
- ack sampled high clears result_valid on the next edge; SYNC starts on that edge.
- Minimum back-to-back: a result may be acked the same cycle result_valid is first seen high.
- busy follows the state register; it goes low one edge after enable falls.

## Test plan
- NUM_CH=3, AVG_LOG2=2, ch0 steady at 30 high / 70 low, ack held 1 -> first result: result_ch=0, high_avg=30, low_avg=70, timeout=0.
- ch1 alternating periods 10H/20L and 11H/21L -> high_avg=10 (42>>2), low_avg=20 (82>>2).
- TIMEOUT_CYCLES=1000, ch2 tied high -> result_ch=2, timeout=1, high_avg=1000, low_avg=0; repeat with ch2 tied low -> high_avg=0, low_avg=1000.
- Hold ack=0 for 500 cycles after result_valid -> outputs stable, busy=1, no channel advance; subsequent acks yield result_ch sequence 1, 2, 0 (wrap).
- Drop enable mid-MEASURE on ch1 -> busy=0 and result_valid=0 within 1 edge; after re-enable the first result is ch0 with correct fresh values.
- Assert reset while result_valid=1 -> all outputs return to 0 the next edge; the scan restarts at ch0 after release with enable=1.

Source files
------------

// File: rtl/pwm_capture_sequencer.sv
// pwm_capture_sequencer
// Round-robin PWM measurement controller. Locks onto each channel's period,
// averages high/low intervals over 2^AVG_LOG2 periods and hands the result to
// the consumer with a valid/ack handshake. Stuck lines are reported through a
// timeout path instead of stalling the scan.
module pwm_capture_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int CNT_W          = 32,
    parameter int AVG_LOG2       = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         pwm_in,
    input  logic                      enable,
    input  logic                      ack,
    output logic                      result_valid,
    output logic [$clog2(NUM_CH)-1:0] result_ch,
    output logic [CNT_W-1:0]          high_avg,
    output logic [CNT_W-1:0]          low_avg,
    output logic                      timeout,
    output logic                      busy
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ACC_W  = CNT_W + AVG_LOG2;
    localparam int NPER_W = AVG_LOG2 + 1;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [NPER_W-1:0] NPER_LAST   = NPER_W'((1 << AVG_LOG2) - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CH_W-1:0]   CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, SYNC, MEASURE, PUBLISH} state_t;

    state_t state;
    state_t state_next;

    logic [NUM_CH-1:0] s1;
    logic [NUM_CH-1:0] s2;
    logic [NUM_CH-1:0] s3;

    logic [CH_W-1:0]   cur_ch;
    logic [CNT_W-1:0]  hcnt;
    logic [CNT_W-1:0]  lcnt;
    logic [ACC_W-1:0]  hacc;
    logic [ACC_W-1:0]  lacc;
    logic [NPER_W-1:0] nper;
    logic [TCNT_W-1:0] tcnt;

    logic              sel_level;
    logic              sel_rise;
    logic              sel_fall;
    logic              sel_edge;
    logic              tcnt_hit;
    logic              measure_done;
    logic              timed_out;
    logic [ACC_W-1:0]  hsum;
    logic [ACC_W-1:0]  lsum;

    assign sel_level    = s2[cur_ch];
    assign sel_rise     = s2[cur_ch] & ~s3[cur_ch];
    assign sel_fall     = ~s2[cur_ch] & s3[cur_ch];
    assign sel_edge     = sel_rise | sel_fall;
    assign tcnt_hit     = ~sel_edge && (tcnt == TCNT_LAST);
    assign measure_done = (state == MEASURE) && sel_rise && (nper == NPER_LAST);
    assign timed_out    = ((state == SYNC) || (state == MEASURE)) && tcnt_hit;
    assign hsum         = hacc + ACC_W'(hcnt);
    assign lsum         = lacc + ACC_W'(lcnt);
    assign busy         = (state != IDLE);

    // Synchronize every channel continuously so channel switches never see a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decision; dropping enable always parks the scan in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = SYNC;
            end
            SYNC: begin
                if (sel_rise) state_next = MEASURE;
                else if (timed_out) state_next = PUBLISH;
            end
            MEASURE: begin
                if (measure_done || timed_out) state_next = PUBLISH;
            end
            PUBLISH: begin
                if (ack) state_next = SYNC;
            end
            default: state_next = IDLE;
        endcase
        if (!enable) state_next = IDLE;
    end

    // Interval counting, accumulation, timeout tracking and result loading.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ch       <= '0;
            hcnt         <= '0;
            lcnt         <= '0;
            hacc         <= '0;
            lacc         <= '0;
            nper         <= '0;
            tcnt         <= '0;
            result_valid <= 1'b0;
            result_ch    <= '0;
            high_avg     <= '0;
            low_avg      <= '0;
            timeout      <= 1'b0;
        end else if (!enable) begin
            cur_ch       <= '0;
            tcnt         <= '0;
            result_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cur_ch <= '0;
                    tcnt   <= '0;
                end
                SYNC, MEASURE: begin
                    if (sel_edge) tcnt <= '0;
                    else if (!tcnt_hit) tcnt <= tcnt + TCNT_W'(1);

                    if (state == SYNC) begin
                        if (sel_rise) begin
                            hcnt <= CNT_W'(1);
                            lcnt <= '0;
                            hacc <= '0;
                            lacc <= '0;
                            nper <= '0;
                        end
                    end else if (sel_rise) begin
                        hacc <= hsum;
                        lacc <= lsum;
                        nper <= nper + NPER_W'(1);
                        hcnt <= CNT_W'(1);
                        lcnt <= '0;
                    end else if (sel_level) begin
                        if (hcnt != '1) hcnt <= hcnt + CNT_W'(1);
                    end else begin
                        if (lcnt != '1) lcnt <= lcnt + CNT_W'(1);
                    end

                    if (measure_done) begin
                        result_valid <= 1'b1;
                        result_ch    <= cur_ch;
                        high_avg     <= CNT_W'(hsum >> AVG_LOG2);
                        low_avg      <= CNT_W'(lsum >> AVG_LOG2);
                        timeout      <= 1'b0;
                    end else if (timed_out) begin
                        result_valid <= 1'b1;
                        result_ch    <= cur_ch;
                        high_avg     <= sel_level ? TIMEOUT_VAL : '0;
                        low_avg      <= sel_level ? '0 : TIMEOUT_VAL;
                        timeout      <= 1'b1;
                    end
                end
                PUBLISH: begin
                    if (ack) begin
                        result_valid <= 1'b0;
                        cur_ch       <= (cur_ch == CH_LAST) ? '0 : cur_ch + CH_W'(1);
                        tcnt         <= '0;
                    end
                end
                default: begin
                    cur_ch <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture_sequencer.sv
// tb_pwm_capture_sequencer
// Directed bench: free-running PWM generators per channel, scenario tasks
// with hand-computed expected results.
module tb_pwm_capture_sequencer;

    localparam int NUM_CH         = 3;
    localparam int CNT_W          = 32;
    localparam int AVG_LOG2       = 2;
    localparam int TIMEOUT_CYCLES = 1000;
    localparam int WAIT_LIMIT     = 4000;

    localparam int MODE_PWM  = 0;
    localparam int MODE_HIGH = 1;
    localparam int MODE_LOW  = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              ack;
    logic [NUM_CH-1:0] pwm_in;
    logic              result_valid;
    logic [1:0]        result_ch;
    logic [CNT_W-1:0]  high_avg;
    logic [CNT_W-1:0]  low_avg;
    logic              timeout;
    logic              busy;

    int checks = 0;
    int errors = 0;

    int hi_a[NUM_CH];
    int lo_a[NUM_CH];
    int hi_b[NUM_CH];
    int lo_b[NUM_CH];
    int mode[NUM_CH];
    int phase[NUM_CH];
    int rem[NUM_CH];

    pwm_capture_sequencer #(
        .NUM_CH(NUM_CH),
        .CNT_W(CNT_W),
        .AVG_LOG2(AVG_LOG2),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pwm_in(pwm_in),
        .enable(enable),
        .ack(ack),
        .result_valid(result_valid),
        .result_ch(result_ch),
        .high_avg(high_avg),
        .low_avg(low_avg),
        .timeout(timeout),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // PWM generators: phases high A, low A, high B, low B, each held for whole cycles.
    initial begin
        pwm_in = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            phase[c] = 3;
            rem[c]   = 1;
        end
        forever begin
            @(negedge clk);
            for (int c = 0; c < NUM_CH; c++) begin
                if (rem[c] <= 1) begin
                    phase[c] = (phase[c] + 1) % 4;
                    case (phase[c])
                        0:       rem[c] = hi_a[c];
                        1:       rem[c] = lo_a[c];
                        2:       rem[c] = hi_b[c];
                        default: rem[c] = lo_b[c];
                    endcase
                end else begin
                    rem[c] = rem[c] - 1;
                end
                case (mode[c])
                    MODE_HIGH: pwm_in[c] = 1'b1;
                    MODE_LOW:  pwm_in[c] = 1'b0;
                    default:   pwm_in[c] = (phase[c] % 2 == 0);
                endcase
            end
        end
    end

    task automatic wait_result(output bit got);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (result_valid !== 1'b1 && n < WAIT_LIMIT);
        got = (result_valid === 1'b1);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b required 0", result_valid); end
        checks++; if (result_ch !== 2'd0) begin errors++; $display("[TB] FAIL reset_ch: got %0d required 0", result_ch); end
        checks++; if (high_avg !== 32'd0) begin errors++; $display("[TB] FAIL reset_high: got %0d required 0", high_avg); end
        checks++; if (low_avg !== 32'd0) begin errors++; $display("[TB] FAIL reset_low: got %0d required 0", low_avg); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout: got %b required 0", timeout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
        // Let the synchronizer history catch up with the pins before scanning,
        // so a line already high at release is not taken as a fresh rise.
        reset = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_steady_ch0();
        bit got;
        enable = 1'b1;
        ack    = 1'b1;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL steady_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd0, 32'd30, 32'd70, 1'b0}) begin
            errors++;
            $display("[TB] FAIL steady_ch0: got ch=%0d high=%0d low=%0d to=%b, required ch=0 high=30 low=70 to=0", result_ch, high_avg, low_avg, timeout);
        end
    endtask

    task automatic test_alternating_ch1();
        bit got;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL alt_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd1, 32'd10, 32'd20, 1'b0}) begin
            errors++;
            $display("[TB] FAIL alt_ch1: got ch=%0d high=%0d low=%0d to=%b, required ch=1 high=10 low=20 to=0", result_ch, high_avg, low_avg, timeout);
        end
    endtask

    task automatic test_timeout_high();
        bit got;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL to_high_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd2, 32'd1000, 32'd0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL to_high_ch2: got ch=%0d high=%0d low=%0d to=%b, required ch=2 high=1000 low=0 to=1", result_ch, high_avg, low_avg, timeout);
        end
        mode[2] = MODE_LOW;
    endtask

    task automatic test_timeout_low();
        bit got;
        logic [1:0]       exp_ch[3] = '{2'd0, 2'd1, 2'd2};
        logic [CNT_W-1:0] exp_hi[3] = '{32'd30, 32'd10, 32'd0};
        logic [CNT_W-1:0] exp_lo[3] = '{32'd70, 32'd20, 32'd1000};
        logic             exp_to[3] = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            wait_result(got);
            checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL to_low_wait%0d: result_valid not seen within %0d cycles", k, WAIT_LIMIT); end
            checks++;
            if ({result_ch, high_avg, low_avg, timeout} !== {exp_ch[k], exp_hi[k], exp_lo[k], exp_to[k]}) begin
                errors++;
                $display("[TB] FAIL to_low_res%0d: got ch=%0d high=%0d low=%0d to=%b, required ch=%0d high=%0d low=%0d to=%b",
                         k, result_ch, high_avg, low_avg, timeout, exp_ch[k], exp_hi[k], exp_lo[k], exp_to[k]);
            end
        end
    endtask

    task automatic test_ack_stall();
        bit got;
        int bad;
        logic [1:0]       exp_ch[3] = '{2'd1, 2'd2, 2'd0};
        logic [CNT_W-1:0] exp_hi[3] = '{32'd10, 32'd0, 32'd30};
        logic [CNT_W-1:0] exp_lo[3] = '{32'd20, 32'd1000, 32'd70};
        logic             exp_to[3] = '{1'b0, 1'b1, 1'b0};
        @(negedge clk);
        ack = 1'b0;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL stall_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd0, 32'd30, 32'd70, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_first: got ch=%0d high=%0d low=%0d to=%b, required ch=0 high=30 low=70 to=0", result_ch, high_avg, low_avg, timeout);
        end
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if ({result_valid, busy, result_ch, high_avg, low_avg, timeout} !== {1'b1, 1'b1, 2'd0, 32'd30, 32'd70, 1'b0}) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall_stable: %0d unstable cycles, required 0", bad); end
        for (int k = 0; k < 3; k++) begin
            ack = 1'b1;
            @(negedge clk);
            ack = 1'b0;
            checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_clear%0d: result_valid=%b required 0", k, result_valid); end
            wait_result(got);
            checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL seq_wait%0d: result_valid not seen within %0d cycles", k, WAIT_LIMIT); end
            checks++;
            if ({result_ch, high_avg, low_avg, timeout} !== {exp_ch[k], exp_hi[k], exp_lo[k], exp_to[k]}) begin
                errors++;
                $display("[TB] FAIL seq_res%0d: got ch=%0d high=%0d low=%0d to=%b, required ch=%0d high=%0d low=%0d to=%b",
                         k, result_ch, high_avg, low_avg, timeout, exp_ch[k], exp_hi[k], exp_lo[k], exp_to[k]);
            end
        end
    endtask

    task automatic test_enable_abort();
        bit got;
        ack = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if ({busy, result_valid} !== 2'b10) begin errors++; $display("[TB] FAIL abort_pre: busy=%b valid=%b, required busy=1 valid=0", busy, result_valid); end
        enable = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b required 0", busy); end
        checks++; if (result_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_valid: got %b required 0", result_valid); end
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL reenable_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd0, 32'd30, 32'd70, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reenable_ch0: got ch=%0d high=%0d low=%0d to=%b, required ch=0 high=30 low=70 to=0", result_ch, high_avg, low_avg, timeout);
        end
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset_during_valid();
        bit got;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL rv_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd1, 32'd10, 32'd20, 1'b0}) begin
            errors++;
            $display("[TB] FAIL rv_ch1: got ch=%0d high=%0d low=%0d to=%b, required ch=1 high=10 low=20 to=0", result_ch, high_avg, low_avg, timeout);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({result_valid, result_ch, high_avg, low_avg, timeout, busy} !== 69'd0) begin
            errors++;
            $display("[TB] FAIL rv_reset: got valid=%b ch=%0d high=%0d low=%0d to=%b busy=%b, required all 0",
                     result_valid, result_ch, high_avg, low_avg, timeout, busy);
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (4) @(negedge clk);
        enable = 1'b1;
        ack    = 1'b1;
        wait_result(got);
        checks++; if (got !== 1'b1) begin errors++; $display("[TB] FAIL restart_wait: result_valid not seen within %0d cycles", WAIT_LIMIT); end
        checks++;
        if ({result_ch, high_avg, low_avg, timeout} !== {2'd0, 32'd30, 32'd70, 1'b0}) begin
            errors++;
            $display("[TB] FAIL restart_ch0: got ch=%0d high=%0d low=%0d to=%b, required ch=0 high=30 low=70 to=0", result_ch, high_avg, low_avg, timeout);
        end
    endtask

    // Channel setup and scenario sequence.
    initial begin
        hi_a[0] = 30; lo_a[0] = 70; hi_b[0] = 30; lo_b[0] = 70; mode[0] = MODE_PWM;
        hi_a[1] = 10; lo_a[1] = 20; hi_b[1] = 11; lo_b[1] = 21; mode[1] = MODE_PWM;
        hi_a[2] = 50; lo_a[2] = 50; hi_b[2] = 50; lo_b[2] = 50; mode[2] = MODE_HIGH;
        reset  = 1'b1;
        enable = 1'b0;
        ack    = 1'b0;

        test_reset();
        test_steady_ch0();
        test_alternating_ch1();
        test_timeout_high();
        test_timeout_low();
        test_ack_stall();
        test_enable_abort();
        test_reset_during_valid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
